// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and ZADL vector-select codes for the interrupt sequencer.
package cpu_pkg;
    typedef enum logic [1:0] {VEC_NONE, VEC_NMI, VEC_RST, VEC_IRQ} vec_src_t;
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_SVC} irq_state_t;
    localparam logic [2:0] ZADL_NMI_LO = 3'b101;
    localparam logic [2:0] ZADL_NMI_HI = 3'b100;
    localparam logic [2:0] ZADL_RST_LO = 3'b011;
    localparam logic [2:0] ZADL_RST_HI = 3'b010;
    localparam logic [2:0] ZADL_IRQ_LO = 3'b001;
    localparam logic [2:0] ZADL_IRQ_HI = 3'b000;
    function automatic logic [2:0] zadl_of(vec_src_t s, logic hi);
        return s == VEC_NMI ? (hi ? ZADL_NMI_HI : ZADL_NMI_LO) :
               s == VEC_RST ? (hi ? ZADL_RST_HI : ZADL_RST_LO) :
                              (hi ? ZADL_IRQ_HI : ZADL_IRQ_LO);
    endfunction
endpackage

// File: rtl/irq_edge_filter.sv
// irq_edge_filter: qualifies an NMI falling edge after NMI_MIN_LOW consecutive low samples.
// The saturating count re-arms only once the pin is sampled high again.
module irq_edge_filter #(
    parameter int NMI_MIN_LOW = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_nmi_n,
    output logic o_edge
);
    localparam logic [3:0] MAX = 4'(NMI_MIN_LOW);
    logic [3:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d  = i_nmi_n ? 4'd0 : (cnt_q == MAX ? cnt_q : cnt_q + 4'd1);
        o_edge = !i_nmi_n && (cnt_q == MAX - 4'd1);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= 4'd0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/irq_ctl.sv
// irq_ctl: NMI/IRQ/RESET sequencer driving BRK injection and ZADL vector selection.
// Define IRQ_CTL_SYNC_EN to pass the NMI/IRQ pins through 2-flop synchronisers.
module irq_ctl
    import cpu_pkg::*;
#(
    parameter int NMI_MIN_LOW = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_nmi_n,
    input  logic       i_irq_n,
    input  logic       i_ready,
    input  logic       i_flag_i,
    input  logic       i_sync,
    input  logic       i_brk,
    input  logic       i_vec_lo,
    input  logic       i_vec_hi,
    output logic       o_int_req,
    output logic       o_rst_seq,
    output logic       o_b_flag,
    output logic [2:0] o_zadl,
    output logic [1:0] o_vec_sel
);
    logic nmi_n, irq_n, nmi_edge;
`ifdef IRQ_CTL_SYNC_EN
    logic [1:0] nmi_sync_q, irq_sync_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            nmi_sync_q <= 2'b11;
            irq_sync_q <= 2'b11;
        end else begin
            nmi_sync_q <= {nmi_sync_q[0], i_nmi_n};
            irq_sync_q <= {irq_sync_q[0], i_irq_n};
        end
    end
    assign nmi_n = nmi_sync_q[1];
    assign irq_n = irq_sync_q[1];
`else
    assign nmi_n = i_nmi_n;
    assign irq_n = i_irq_n;
`endif

    irq_edge_filter #(.NMI_MIN_LOW(NMI_MIN_LOW)) u_nmi (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_nmi_n(nmi_n),
        .o_edge (nmi_edge)
    );

    irq_state_t state_q, state_d;
    vec_src_t   vec_sel_q, vec_sel_d, prio, sel;
    logic rst_pend_q, rst_pend_d, nmi_pend_q, nmi_pend_d;
    logic latched_q, latched_d, rst_seq_q, rst_seq_d, b_flag_q, b_flag_d;
    logic req, hw_entry, sw_entry, do_latch, svc_exit;

    always_comb begin
        req      = rst_pend_q | nmi_pend_q | (!irq_n & !i_flag_i);
        prio     = rst_pend_q ? VEC_RST : nmi_pend_q ? VEC_NMI : VEC_IRQ;
        sel      = latched_q ? vec_sel_q : prio;
        // A hardware request outranks a BRK opcode fetched in the same cycle
        hw_entry = i_ready & i_sync & req &
                   ((state_q == ST_ARMED) | ((state_q == ST_IDLE) & i_brk));
        sw_entry = i_ready & i_sync & i_brk & !req & (state_q == ST_IDLE);
        do_latch = (state_q == ST_SVC) & i_ready & i_vec_lo & !latched_q;
        svc_exit = (state_q == ST_SVC) & i_ready & i_vec_hi;
        state_d  = (hw_entry | sw_entry)                       ? ST_SVC   :
                   svc_exit                                    ? ST_IDLE  :
                   ((state_q == ST_IDLE) & i_ready & req)      ? ST_ARMED :
                   ((state_q == ST_ARMED) & i_ready & i_sync)  ? ST_IDLE  : state_q;
        rst_pend_d = rst_pend_q & !(do_latch & (prio == VEC_RST));
        // An edge arriving in the latch cycle survives and is serviced later
        nmi_pend_d = (nmi_pend_q & !(do_latch & (prio == VEC_NMI))) | nmi_edge;
        vec_sel_d  = do_latch ? prio : vec_sel_q;
        latched_d  = (hw_entry | sw_entry) ? 1'b0 : (do_latch | latched_q);
        rst_seq_d  = hw_entry ? rst_pend_q : (svc_exit ? 1'b0 : rst_seq_q);
        b_flag_d   = sw_entry ? 1'b1 : ((hw_entry | svc_exit) ? 1'b0 : b_flag_q);
        o_int_req  = hw_entry;
        o_rst_seq  = rst_seq_q | (hw_entry & rst_pend_q);
        o_b_flag   = b_flag_q | sw_entry;
        o_zadl     = (state_q != ST_SVC) ? 3'b000 :
                     i_vec_lo ? zadl_of(sel, 1'b0) :
                     i_vec_hi ? zadl_of(sel, 1'b1) : 3'b000;
        o_vec_sel  = vec_sel_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            vec_sel_q  <= VEC_NONE;
            rst_pend_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            latched_q  <= 1'b0;
            rst_seq_q  <= 1'b0;
            b_flag_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_sel_q  <= vec_sel_d;
            rst_pend_q <= rst_pend_d;
            nmi_pend_q <= nmi_pend_d;
            latched_q  <= latched_d;
            rst_seq_q  <= rst_seq_d;
            b_flag_q   <= b_flag_d;
        end
    end
endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: directed self-checking bench for irq_ctl with NMI_MIN_LOW=3.
module tb_irq_ctl;
    logic i_clk = 1'b0, i_rst = 1'b1;
    logic i_nmi_n = 1'b1, i_irq_n = 1'b1, i_ready = 1'b1, i_flag_i = 1'b0;
    logic i_sync = 1'b0, i_brk = 1'b0, i_vec_lo = 1'b0, i_vec_hi = 1'b0;
    logic o_int_req, o_rst_seq, o_b_flag;
    logic [2:0] o_zadl;
    logic [1:0] o_vec_sel;
    int checks = 0, failures = 0;

    irq_ctl #(.NMI_MIN_LOW(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_nmi_n(i_nmi_n), .i_irq_n(i_irq_n),
        .i_ready(i_ready), .i_flag_i(i_flag_i), .i_sync(i_sync), .i_brk(i_brk),
        .i_vec_lo(i_vec_lo), .i_vec_hi(i_vec_hi), .o_int_req(o_int_req),
        .o_rst_seq(o_rst_seq), .o_b_flag(o_b_flag), .o_zadl(o_zadl), .o_vec_sel(o_vec_sel)
    );

    always #5 i_clk = ~i_clk;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sync_exp(input string tag, input logic req, input logic b, input logic rs);
        i_sync = 1'b1;
        @(negedge i_clk);
        chk({tag, "_int_req"}, {2'b0, o_int_req}, {2'b0, req});
        chk({tag, "_b_flag"}, {2'b0, o_b_flag}, {2'b0, b});
        chk({tag, "_rst_seq"}, {2'b0, o_rst_seq}, {2'b0, rs});
        cyc();
        i_sync = 1'b0;
    endtask

    task automatic do_vec(input string tag, input logic [2:0] lo, input logic [2:0] hi,
                          input logic [1:0] sel);
        i_vec_lo = 1'b1;
        @(negedge i_clk);
        chk({tag, "_zadl_lo"}, o_zadl, lo);
        cyc();
        i_vec_lo = 1'b0;
        i_vec_hi = 1'b1;
        @(negedge i_clk);
        chk({tag, "_zadl_hi"}, o_zadl, hi);
        chk({tag, "_vec_sel"}, {1'b0, o_vec_sel}, {1'b0, sel});
        cyc();
        i_vec_hi = 1'b0;
    endtask

    initial begin
        // 1: power-up reset sequence
        repeat (2) cyc();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_int_req", {2'b0, o_int_req}, 3'd0);
        chk("rst_rst_seq", {2'b0, o_rst_seq}, 3'd0);
        chk("rst_b_flag", {2'b0, o_b_flag}, 3'd0);
        chk("rst_zadl", o_zadl, 3'd0);
        chk("rst_vec_sel", {1'b0, o_vec_sel}, 3'd0);
        cyc();
        sync_exp("t1_entry", 1'b1, 1'b0, 1'b1);
        do_vec("t1", 3'b011, 3'b010, 2'd2);
        @(negedge i_clk);
        chk("t1_idle_zadl", o_zadl, 3'd0);
        chk("t1_idle_rst_seq", {2'b0, o_rst_seq}, 3'd0);
        sync_exp("t1_no_repeat", 1'b0, 1'b0, 1'b0);
        // 2: short NMI pulse rejected, long low qualifies exactly once
        i_nmi_n = 1'b0;
        repeat (2) cyc();
        i_nmi_n = 1'b1;
        repeat (2) cyc();
        sync_exp("t2_short", 1'b0, 1'b0, 1'b0);
        i_nmi_n = 1'b0;
        repeat (5) cyc();
        sync_exp("t2_nmi", 1'b1, 1'b0, 1'b0);
        do_vec("t2", 3'b101, 3'b100, 2'd1);
        repeat (2) cyc();
        sync_exp("t2_held_once", 1'b0, 1'b0, 1'b0);
        i_nmi_n = 1'b1;
        cyc();
        // 3: IRQ masked, then unmasked; then a request released before the sync
        i_irq_n = 1'b0;
        i_flag_i = 1'b1;
        repeat (2) cyc();
        sync_exp("t3_masked", 1'b0, 1'b0, 1'b0);
        i_flag_i = 1'b0;
        cyc();
        sync_exp("t3_irq", 1'b1, 1'b0, 1'b0);
        i_irq_n = 1'b1;
        do_vec("t3", 3'b001, 3'b000, 2'd3);
        i_irq_n = 1'b0;
        cyc();
        i_irq_n = 1'b1;
        sync_exp("t3_dropped", 1'b0, 1'b0, 1'b0);
        sync_exp("t3_still_idle", 1'b0, 1'b0, 1'b0);
        // 4: software BRK hijacked by an NMI
        i_sync = 1'b1;
        i_brk = 1'b1;
        @(negedge i_clk);
        chk("t4_brk_int_req", {2'b0, o_int_req}, 3'd0);
        chk("t4_brk_b_flag", {2'b0, o_b_flag}, 3'd1);
        cyc();
        i_sync = 1'b0;
        i_brk = 1'b0;
        i_nmi_n = 1'b0;
        repeat (3) cyc();
        i_nmi_n = 1'b1;
        @(negedge i_clk);
        chk("t4_b_flag_held", {2'b0, o_b_flag}, 3'd1);
        do_vec("t4", 3'b101, 3'b100, 2'd1);
        cyc();
        sync_exp("t4_no_second", 1'b0, 1'b0, 1'b0);
        // 5: stall in the vector-high cycle while a new NMI arrives
        i_nmi_n = 1'b0;
        repeat (3) cyc();
        i_nmi_n = 1'b1;
        cyc();
        sync_exp("t5_entry", 1'b1, 1'b0, 1'b0);
        i_vec_lo = 1'b1;
        @(negedge i_clk);
        chk("t5_zadl_lo", o_zadl, 3'b101);
        cyc();
        i_vec_lo = 1'b0;
        i_vec_hi = 1'b1;
        i_ready = 1'b0;
        i_nmi_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("t5_stall_zadl", o_zadl, 3'b100);
            chk("t5_stall_vec_sel", {1'b0, o_vec_sel}, 3'd1);
            cyc();
        end
        i_ready = 1'b1;
        i_nmi_n = 1'b1;
        cyc();
        i_vec_hi = 1'b0;
        cyc();
        sync_exp("t5_captured", 1'b1, 1'b0, 1'b0);
        do_vec("t5b", 3'b101, 3'b100, 2'd1);
        // 6: reset mid-sequence aborts and re-runs RESET
        i_irq_n = 1'b0;
        cyc();
        sync_exp("t6_irq", 1'b1, 1'b0, 1'b0);
        i_irq_n = 1'b1;
        i_vec_lo = 1'b1;
        cyc();
        i_vec_lo = 1'b0;
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("t6_vec_sel", {1'b0, o_vec_sel}, 3'd0);
        chk("t6_rst_seq", {2'b0, o_rst_seq}, 3'd0);
        chk("t6_int_req", {2'b0, o_int_req}, 3'd0);
        i_vec_hi = 1'b1;
        @(negedge i_clk);
        chk("t6_zadl_idle", o_zadl, 3'd0);
        i_vec_hi = 1'b0;
        cyc();
        sync_exp("t6_reset", 1'b1, 1'b0, 1'b1);
        do_vec("t6", 3'b011, 3'b010, 2'd2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
